// File: rtl/idct2_1d_seq.sv
// Sequential 1-D inverse DCT-II for sizes 4/8/16/32: one 16x8 multiply-accumulate per clock.
// Build option: define IDCT_CLIP_EN to saturate outputs to 16 bits (default wraps).
module idct2_1d_seq #(
    parameter int SHIFT = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         N,
    input  logic signed [0:511] coef_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [0:511] Y
);
    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

    localparam logic signed [31:0] ROUND = 32'sd1 <<< (SHIFT - 1);

    state_t             state, state_next;
    logic [0:511]       coef_q;
    logic [1:0]         size_q;
    logic [4:0]         k, n, last, row;
    logic [6:0]         m, mag;
    logic               neg, accept;
    logic signed [7:0]  tcoef;
    logic signed [15:0] coef_k, result;
    logic signed [23:0] prod;
    logic signed [31:0] acc, acc_next, rounded;
    logic signed [15:0] y_mem [32];

    // Magnitudes of the odd-symmetric cosine basis, indexed by phase 1..32.
    function automatic logic [6:0] base_mag(input logic [5:0] i);
        case (i)
            6'd1, 6'd2, 6'd3: base_mag = 7'd90;
            6'd4:  base_mag = 7'd89;  6'd5:  base_mag = 7'd88;  6'd6:  base_mag = 7'd87;
            6'd7:  base_mag = 7'd85;  6'd8:  base_mag = 7'd83;  6'd9:  base_mag = 7'd82;
            6'd10: base_mag = 7'd80;  6'd11: base_mag = 7'd78;  6'd12: base_mag = 7'd75;
            6'd13: base_mag = 7'd73;  6'd14: base_mag = 7'd70;  6'd15: base_mag = 7'd67;
            6'd16: base_mag = 7'd64;  6'd17: base_mag = 7'd61;  6'd18: base_mag = 7'd57;
            6'd19: base_mag = 7'd54;  6'd20: base_mag = 7'd50;  6'd21: base_mag = 7'd46;
            6'd22: base_mag = 7'd43;  6'd23: base_mag = 7'd38;  6'd24: base_mag = 7'd36;
            6'd25: base_mag = 7'd31;  6'd26: base_mag = 7'd25;  6'd27: base_mag = 7'd22;
            6'd28: base_mag = 7'd18;  6'd29: base_mag = 7'd13;  6'd30: base_mag = 7'd9;
            6'd31: base_mag = 7'd4;
            default: base_mag = 7'd0;
        endcase
    endfunction

    always_comb begin
        case (size_q)
            2'd0:    last = 5'd3;
            2'd1:    last = 5'd7;
            2'd2:    last = 5'd15;
            default: last = 5'd31;
        endcase
    end

    // Row of the 32-point matrix for term k, then its phase (2n+1)*row mod 128.
    // NOTE: every variable gets a default before the branches so no latch is inferred.
    always_comb begin
        row = k << (2'd3 - size_q);
        m   = {1'b0, n, 1'b1} * {2'b00, row};
        neg = 1'b0;
        mag = 7'd64;
        if (row != 5'd0) begin
            if (m <= 7'd32) begin
                mag = base_mag(m[5:0]);
            end else if (m <= 7'd64) begin
                mag = base_mag(6'(7'd64 - m));
                neg = 1'b1;
            end else if (m <= 7'd96) begin
                mag = base_mag(6'(m - 7'd64));
                neg = 1'b1;
            end else begin
                mag = base_mag(6'(8'd128 - {1'b0, m}));
            end
        end
        tcoef = neg ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
    end

    assign coef_k   = coef_q[{k, 4'b0000} +: 16];
    assign prod     = 24'(coef_k) * 24'(tcoef);
    assign acc_next = acc + 32'(prod);
    assign rounded  = (acc_next + ROUND) >>> SHIFT;

    always_comb begin
`ifdef IDCT_CLIP_EN
        if (rounded > 32'sd32767)       result = 16'sh7fff;
        else if (rounded < -32'sd32768) result = 16'sh8000;
        else                            result = rounded[15:0];
`else
        result = rounded[15:0];
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = MAC;
            end
            MAC:  if (k == last && n == last) state_next = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign accept = in_valid && in_ready;

    // NOTE: Y is reset because it is visible at the port; coef_q is only read after an accept, so it is not.
    always_ff @(posedge clk) begin
        if (accept) coef_q <= coef_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            k      <= '0;
            n      <= '0;
            size_q <= '0;
            for (int i = 0; i < 32; i++) y_mem[i] <= '0;
        end else if (accept) begin
            acc    <= '0;
            k      <= '0;
            n      <= '0;
            size_q <= N;
            for (int i = 0; i < 32; i++) y_mem[i] <= '0;
        end else if (state == MAC) begin
            if (k == last) begin
                y_mem[n] <= result;
                acc      <= '0;
                k        <= '0;
                n        <= n + 5'd1;
            end else begin
                acc <= acc_next;
                k   <= k + 5'd1;
            end
        end
    end

    always_comb begin
        Y = '0;
        for (int i = 0; i < 32; i++) Y[16*i +: 16] = y_mem[i];
    end

endmodule

// File: doc/idct2_1d_seq.md
IDCT2_1D_SEQ -- requirements
Module: idct2_1d_seq

Interface
REQ-001 SHALL have parameter SHIFT, default 7: right-shift applied to each accumulated output, with round-half-up.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1 bit: a coefficient vector is offered.
REQ-005 SHALL have port in_ready, output, 1 bit: the block can accept a vector.
REQ-006 SHALL have port N, input, 2 bits: transform size, 00=4, 01=8, 10=16, 11=32, sampled on accept.
REQ-007 SHALL have port coef_in, input, signed [0:511]: 32 signed 16-bit coefficients; element k occupies bits [16k:16k+15], MSB first.
REQ-008 SHALL have port out_valid, output, 1 bit: the residual vector Y is valid.
REQ-009 SHALL have port out_ready, input, 1 bit: the consumer accepts Y.
REQ-010 SHALL have port Y, output, signed [0:511]: 32 signed 16-bit samples, packed the same way as coef_in.

Function
REQ-011 SHALL compute, for size S, Y[n] = (sum over k<S of coef[k]*T32[k*32/S][n] + 2^(SHIFT-1)) >>> SHIFT, for n<S.
REQ-012 SHALL use the following coefficient rule:
- T32[0][n] = 64.
- For k>0, take m = ((2n+1)*k) mod 128 and look up base[m]:
  - m<=32: +base[m]
  - 33..64: -base[64-m]
  - 65..96: -base[m-64]
  - 97..127: +base[128-m]
REQ-013 SHALL use base[1..32] = 90,90,90,89,88,87,85,83,82,80,78,75,73,70,67,64,61,57,54,50,46,43,38,36,31,25,22,18,13,9,4,0.
REQ-014 SHALL generate coefficients with a lookup or function; no full 32x32 matrix storage.
REQ-015 SHALL use exactly one signed 16x8 multiplier and a signed accumulator of at least 32 bits; the shift SHALL be arithmetic.
REQ-016 SHALL implement FSM states IDLE, MAC and DONE.
REQ-017 SHALL in IDLE drive in_ready=1; on in_valid&&in_ready it SHALL latch coef_in and N, clear acc, set k=0 and n=0, and go to MAC.
REQ-018 SHALL in MAC perform one term per cycle: acc += coef[k]*T.
REQ-019 SHALL at k==S-1 write the rounded result into Y[n], clear acc, set k=0 and n=n+1.
REQ-020 SHALL go to DONE at k==S-1 && n==S-1.
REQ-021 SHALL take exactly S*S cycles in MAC; out_valid SHALL rise on cycle S*S+1 after the accept edge.
REQ-022 SHALL in DONE hold out_valid=1 with Y stable, and go to IDLE on out_ready.
REQ-023 SHALL drive in_ready=0 in MAC and DONE; in_valid SHALL be ignored in those states, with no overlap of vectors.
REQ-024 SHALL drive Y elements n>=S to 0.
REQ-025 SHALL clear all Y elements on accept.
REQ-026 SHALL not change Y while out_valid=1 and out_ready=0.

Reset
REQ-027 SHALL on rst=1 enter IDLE and set out_valid=0, in_ready=1 (the first cycle after release), Y=0, acc=0, k=0, n=0.
REQ-028 SHALL give rst priority over every handshake; reset in MAC or DONE SHALL discard the current vector with no partial output.

Configuration
REQ-029 SHALL, with IDCT_CLIP_EN defined, saturate each shifted result to [-32768, 32767].
REQ-030 SHALL, without IDCT_CLIP_EN, take the low 16 bits of each shifted result (two's-complement wrap).

Verification
REQ-031 SHALL cover: SHIFT=7, N=00, coef[0]=64, rest 0 -> Y[0..3]=32, Y[4..31]=0, out_valid 17 cycles after accept.
REQ-032 SHALL cover: N=11, coef[1]=128, rest 0 -> Y[0]=90, Y[15]=4, Y[16]=-4, Y[31]=-90, out_valid 1025 cycles after accept.
REQ-033 SHALL cover: N=00, coef[0..3]=32767 -> Y[0]=32767 with IDCT_CLIP_EN defined; Y[0]=-2306 without it.
REQ-034 SHALL cover: N=00, coef[0]=-1 -> Y[0..3]=0; coef[0]=-2 -> Y[0..3]=-1 (rounding and arithmetic shift).
REQ-035 SHALL cover: out_ready=0 for 10 cycles in DONE while in_valid=1 -> Y and out_valid stable, in_ready=0, the new vector is accepted only after the out_ready handshake and the return to IDLE.
REQ-036 SHALL cover: rst=1 for one cycle at MAC cycle 500 with N=11 -> next cycle out_valid=0, Y=0, in_ready=1, and a fresh vector then completes correctly.
